// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one single-port memory between instruction fetch and load/store.
// Only one transaction is in flight at a time. Read data is routed back to the requester that issued the read.
module mem_arbiter #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [2:0] CNT_INIT = 3'(RD_LAT - 1);

  state_t     state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic       owner, owner_nxt;
  logic       last, last_nxt;
  logic       win_if, win_d;

  assign if_rdata = mem_rdata;
  assign d_rdata  = mem_rdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 3'd0;
      owner <= 1'b0;
      last  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      owner <= owner_nxt;
      last  <= last_nxt;
    end
  end

  // Outputs are gated by reset so grants and strobes stay low while it is held.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    owner_nxt = owner;
    last_nxt  = last;
    win_if    = 1'b0;
    win_d     = 1'b0;
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    busy      = 1'b0;

    if (reset) begin
      case (state)
        IDLE: begin
          // On a conflict the side that did not win last time goes first.
          win_d  = d_req && (!if_req || !last);
          win_if = if_req && !win_d;
          if (win_d) begin
            d_gnt     = 1'b1;
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
          end else if (win_if) begin
            if_gnt   = 1'b1;
            mem_en   = 1'b1;
            mem_addr = if_addr;
          end
          if (if_req && d_req) begin
            last_nxt = win_d;
          end
          if (win_if || (win_d && !d_we)) begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_INIT;
            owner_nxt = win_d;
          end
        end
        WAIT: begin
          busy = 1'b1;
          if (cnt == 3'd0) begin
            if_rvalid = !owner;
            d_rvalid  = owner;
            state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt - 3'd1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares one single-port unified memory between the core's instruction-fetch port and its load/store port. It sits between `riscv_core` and a single memory macro, replacing separate instruction and data memories. One transaction is in flight at a time. Read data returns after a fixed latency and is routed back to the requester that issued the read.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width
- `RD_LAT`, 2, memory read latency in cycles from the `mem_en` cycle to valid `mem_rdata`; legal range 1..4
- `clk`  in  1  clock; all state changes on the rising edge
- `reset`  in  1  one clock; reset is asynchronous and active-low
- `if_req`  in  1  fetch read request; held with `if_addr` stable until `if_gnt`
- `if_addr`  in  AW  fetch address
- `if_gnt`  out  1  fetch request accepted this cycle
- `if_rvalid`  out  1  one-cycle pulse; `if_rdata` valid
- `if_rdata`  out  DW  fetch read data
- `d_req`  in  1  data request; held with `d_we`, `d_addr` and `d_wdata` stable until `d_gnt`
- `d_we`  in  1  1 = write, 0 = read
- `d_addr`  in  AW  data address
- `d_wdata`  in  DW  write data
- `d_gnt`  out  1  data request accepted this cycle
- `d_rvalid`  out  1  one-cycle pulse; `d_rdata` valid (reads only)
- `d_rdata`  out  DW  data read data
- `mem_en`  out  1  memory access strobe
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  AW  memory address
- `mem_wdata`  out  DW  memory write data
- `mem_rdata`  in  DW  memory read data, valid `RD_LAT` cycles after the `mem_en` read cycle
- `busy`  out  1  a read is outstanding

## Operation
- FSM states: IDLE and WAIT. A 3-bit latency counter `cnt`, a 1-bit `owner` (0 = IF, 1 = D) and a 1-bit `last` (last winner of a conflict).
- **IDLE**
  - If no request is pending, all strobes are 0.
  - If exactly one request is pending, that requester wins.
  - If both requests are pending, the requester that is not `last` wins. `last` then updates to the winner.
- **Grant cycle** (IDLE with a winner)
  - The winner's `*_gnt` is 1. This is combinational from the `*_req` inputs.
  - `mem_en` is 1, and `mem_addr`, `mem_we` and `mem_wdata` come from the winner. IF requests always drive `mem_we` = 0.
- **Write grant**: the write completes in the grant cycle and the FSM stays in IDLE. The next request can be granted in the following cycle. No `rvalid` is produced.
- **Read grant**: the FSM moves to WAIT with `cnt` = `RD_LAT` − 1 and `owner` = the winner.
- **WAIT**
  - No grants are given and `mem_en` = 0. `cnt` decrements each cycle.
  - In the cycle where `cnt` = 0, the owner's `*_rvalid` is 1 and `*_rdata` = `mem_rdata` (pass-through). The FSM then returns to IDLE.
- **Read data outputs**: `if_rdata` and `d_rdata` carry `mem_rdata` at all times. Their values only have meaning when the matching `rvalid` is 1.
- **`busy`**: 1 exactly while the FSM is in WAIT.
- **Unselected requester**: a requester that loses or is blocked keeps its request asserted. No request is ever dropped.

## Timing
- Reset low sets state to IDLE, `cnt` to 0, `owner` to 0 and `last` to 0 (IF). Reset is asynchronous.
- While reset is low, all outputs are 0: `*_gnt`, `*_rvalid`, `mem_en`, `mem_we` and `busy`. `mem_addr` and `mem_wdata` are also 0.
- Reset asserted during WAIT abandons the read: no `rvalid` is issued after reset is released.
- Read latency is `RD_LAT` cycles from `gnt` to `rvalid`.
- Read throughput is one read per `RD_LAT` + 1 cycles, because a new grant is possible in the cycle after `rvalid`. Writes sustain one per cycle.
- The first conflict after reset goes to D, because `last` resets to IF. Conflicts then alternate.
- A request that arrives during WAIT is granted in the first IDLE cycle.
- `rvalid` and a new `gnt` never occur in the same cycle.

## Test plan
- **Single fetch**, `RD_LAT` = 2, memory preloaded with [0x100] = 0xDEADBEEF:
  - Stimulus: `if_req` = 1 with `if_addr` = 0x100 at cycle 0.
  - Response: `if_gnt`, `mem_en` = 1 and `mem_addr` = 0x100 at cycle 0; `busy` = 1 in cycles 1–2; `if_rvalid` = 1 with `if_rdata` = 0xDEADBEEF at cycle 2.
- **Conflict fairness**:
  - Stimulus: `if_req` and `d_req` (read 0x200) held continuously from cycle 0.
  - Response: D is granted at cycle 0 and IF at cycle 3. With both requests held, the grants keep alternating D, IF, D every 3 cycles.
- **Write streaming**:
  - Stimulus: `d_req` = 1 and `d_we` = 1 with addresses 0x10, 0x14, 0x18 on consecutive cycles.
  - Response: `d_gnt` = 1 on all three cycles; `mem_we` = 1; `busy` stays 0; no `d_rvalid`.
- **Blocked request**:
  - Stimulus: an IF read is granted at cycle 0; `d_req` (read) asserts at cycle 1.
  - Response: `d_gnt` = 0 at cycles 1–2; `if_rvalid` at cycle 2; `d_gnt` at cycle 3; `d_rvalid` at cycle 5.
- **Reset mid-read**:
  - Stimulus: reset driven low at cycle 1 of a D read, released at cycle 4.
  - Response: all outputs are 0 during reset; no `d_rvalid` ever appears; the next `if_req` is granted normally.
- **`RD_LAT` = 1 build**:
  - Stimulus: back-to-back IF reads.
  - Response: a grant every 2 cycles, with `rvalid` one cycle after each grant.
